tgbase64_stream_packer: RTL and testbench

//  Serial front-end for the tgBASE64 conversion datapath. Accepts one 7-bit ASCII char per

---
 rtl/tgbase64_stream_packer_if.sv | 25 ++
 rtl/tgbase64_stream_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_tgbase64_stream_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tgbase64_stream_packer_if.sv
// Stream bundle for the tgBASE64 serial packer.
// The slave modport is the packer's view: it consumes the char stream and
// produces the group stream. The master modport is the view of the logic
// around the packer, which feeds chars and takes groups.
interface tgbase64_stream_packer_if;
    logic        s_valid;
    logic        s_ready;
    logic [6:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic [2:0]  m_nsym;
    logic        m_last;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_nsym, m_last
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_nsym, m_last
    );
endinterface

// File: rtl/tgbase64_stream_packer.sv
// tgbase64_stream_packer: serial tgBASE64 front-end.
// Takes one 7-bit ASCII char per handshake, maps it to a 6-bit code through a
// single shared lookup, and packs up to four codes into a 24-bit group
// (sym0 in the top bits). Messages are capped at MAX_LEN chars; the capping
// char ends the message just as s_last would.
// Optional feature: define STRICT_CHECK_EN to add the err output, which flags
// any unmapped char seen in the current message.
module tgbase64_stream_packer #(
    parameter int MAX_LEN = 146,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    tgbase64_stream_packer_if.slave  bus,
    output logic [CNT_W-1:0]         msg_len,
`ifdef STRICT_CHECK_EN
    output logic                     err,
`endif
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PACK = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    // ASCII -> tgBASE64 code; anything outside the table maps to 0.
    function automatic logic [5:0] map_char(input logic [6:0] c);
        logic [5:0] code;
        code = 6'd0;
        if (c == 7'd32) begin
            code = 6'd0;
        end else if (c == 7'd33) begin
            code = 6'd1;
        end else if ((c >= 7'd48) && (c <= 7'd57)) begin
            code = 6'(c - 7'd46);
        end else if ((c >= 7'd65) && (c <= 7'd90)) begin
            code = 6'(c - 7'd53);
        end else if ((c >= 7'd97) && (c <= 7'd122)) begin
            code = 6'(c - 7'd59);
        end else begin
            code = 6'd0;
        end
        return code;
    endfunction

`ifdef STRICT_CHECK_EN
    // True when the char has an entry in the table (space and '!' included).
    function automatic logic is_mapped(input logic [6:0] c);
        logic ok;
        ok = 1'b0;
        if ((c == 7'd32) || (c == 7'd33)) begin
            ok = 1'b1;
        end else if (((c >= 7'd48) && (c <= 7'd57)) ||
                     ((c >= 7'd65) && (c <= 7'd90)) ||
                     ((c >= 7'd97) && (c <= 7'd122))) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction
`endif

    logic [1:0]       state_r, state_s;
    logic             s_ready_r, s_ready_s;
    logic             m_valid_r, m_valid_s;
    logic             busy_r, busy_s;
    logic [23:0]      data_r, data_s;
    logic [2:0]       nsym_r, nsym_s;
    logic             last_r, last_s;
    logic [1:0]       idx_r, idx_s;
    logic [CNT_W-1:0] len_r, len_s;
    logic             fire_s_s, fire_m_s;
    logic [5:0]       code_s;
    logic [CNT_W-1:0] len_inc_s;
    logic             cap_s;
`ifdef STRICT_CHECK_EN
    logic             err_r, err_s;
    logic             bad_s;
`endif

    // Handshake qualifiers and the per-char lookup shared by every slot.
    always_comb begin
        fire_s_s  = bus.s_valid & s_ready_r;
        fire_m_s  = m_valid_r & bus.m_ready;
        code_s    = map_char(bus.s_data);
        len_inc_s = (len_r == {CNT_W{1'b1}}) ? len_r : (len_r + ONE_C);
        cap_s     = (len_inc_s == MAX_LEN_C);
`ifdef STRICT_CHECK_EN
        bad_s     = ~is_mapped(bus.s_data);
`endif
    end

    // Next-state, slot packing and message framing.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        nsym_s  = nsym_r;
        last_s  = last_r;
        idx_s   = idx_r;
        len_s   = len_r;
`ifdef STRICT_CHECK_EN
        err_s   = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (fire_s_s) begin
                    data_s = {code_s, 18'd0};
                    nsym_s = 3'd1;
                    idx_s  = 2'd1;
                    len_s  = ONE_C;
`ifdef STRICT_CHECK_EN
                    err_s  = bad_s;
`endif
                    if (bus.s_last || (ONE_C == MAX_LEN_C)) begin
                        last_s  = 1'b1;
                        state_s = ST_EMIT;
                    end else begin
                        last_s  = 1'b0;
                        state_s = ST_PACK;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PACK: begin
                if (fire_s_s) begin
                    case (idx_r)
                        2'd0:    data_s[23:18] = code_s;
                        2'd1:    data_s[17:12] = code_s;
                        2'd2:    data_s[11:6]  = code_s;
                        2'd3:    data_s[5:0]   = code_s;
                        default: data_s        = data_r;
                    endcase
                    nsym_s = nsym_r + 3'd1;
                    idx_s  = idx_r + 2'd1;
                    len_s  = len_inc_s;
`ifdef STRICT_CHECK_EN
                    err_s  = err_r | bad_s;
`endif
                    if ((idx_r == 2'd3) || bus.s_last || cap_s) begin
                        last_s  = bus.s_last | cap_s;
                        state_s = ST_EMIT;
                    end else begin
                        last_s  = 1'b0;
                        state_s = ST_PACK;
                    end
                end else begin
                    state_s = ST_PACK;
                end
            end
            ST_EMIT: begin
                if (fire_m_s) begin
                    data_s  = 24'd0;
                    nsym_s  = 3'd0;
                    last_s  = 1'b0;
                    idx_s   = 2'd0;
                    state_s = last_r ? ST_IDLE : ST_PACK;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                data_s  = 24'd0;
                nsym_s  = 3'd0;
                last_s  = 1'b0;
                idx_s   = 2'd0;
            end
        endcase
        s_ready_s = (state_s != ST_EMIT);
        m_valid_s = (state_s == ST_EMIT);
        busy_s    = (state_s != ST_IDLE);
    end

    // State and output registers; reset clears everything including s_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            data_r    <= 24'd0;
            nsym_r    <= 3'd0;
            last_r    <= 1'b0;
            idx_r     <= 2'd0;
            len_r     <= {CNT_W{1'b0}};
`ifdef STRICT_CHECK_EN
            err_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            s_ready_r <= s_ready_s;
            m_valid_r <= m_valid_s;
            busy_r    <= busy_s;
            data_r    <= data_s;
            nsym_r    <= nsym_s;
            last_r    <= last_s;
            idx_r     <= idx_s;
            len_r     <= len_s;
`ifdef STRICT_CHECK_EN
            err_r     <= err_s;
`endif
        end
    end

    assign bus.s_ready = s_ready_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = data_r;
    assign bus.m_nsym  = nsym_r;
    assign bus.m_last  = last_r;
    assign msg_len     = len_r;
    assign busy        = busy_r;
`ifdef STRICT_CHECK_EN
    assign err         = err_r;
`endif

endmodule

// File: tb/tb_tgbase64_stream_packer.sv
// Bench for tgbase64_stream_packer: random and directed char streams, a
// queue-based reference model of message/group framing, and a per-cycle
// compare of the group stream against it.
module tb_tgbase64_stream_packer;

    localparam int MAX_LEN = 146;
    localparam int CNT_W   = 8;

    typedef struct {
        logic [23:0] data;
        int          nsym;
        bit          last;
        int          len;
    } grp_t;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] msg_len;
    logic             busy;
`ifdef STRICT_CHECK_EN
    logic             err;
`endif

    tgbase64_stream_packer_if bif ();

    tgbase64_stream_packer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif),
        .msg_len (msg_len),
`ifdef STRICT_CHECK_EN
        .err     (err),
`endif
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    string alph = " !0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mr_mode = 1;
    grp_t exp_q[$];
    grp_t rx_q[$];
    int   cur_q[$];
    int   cur_cnt = 0;
    bit   new_msg = 1'b1;

    // Code of a char = its position in the table string, else 0.
    function automatic int model_code(input int c);
        for (int i = 0; i < 64; i++) begin
            if (int'(alph[i]) == c) return i;
        end
        return 0;
    endfunction

    // Reference model: one accepted char.
    task automatic model_accept(input int c, input bit l);
        grp_t g;
        bit   msg_end;
        cur_q.push_back(model_code(c));
        cur_cnt = new_msg ? 1 : cur_cnt + 1;
        new_msg = 1'b0;
        msg_end = l || (cur_cnt == MAX_LEN);
        if (msg_end || (cur_q.size() == 4)) begin
            g.data = 24'd0;
            for (int k = 0; k < cur_q.size(); k++)
                g.data = g.data | (24'(cur_q[k]) << (18 - 6 * k));
            g.nsym = cur_q.size();
            g.last = msg_end;
            g.len  = cur_cnt;
            exp_q.push_back(g);
            cur_q.delete();
            if (msg_end) new_msg = 1'b1;
        end
    endtask

    // Per-cycle check of the group stream and char-side capture.
    task automatic monitor();
        grp_t g, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_q.delete();
                exp_q.delete();
                new_msg = 1'b1;
                cur_cnt = 0;
            end else begin
                if (bif.m_valid) begin
                    g.data = bif.m_data;
                    g.nsym = int'(bif.m_nsym);
                    g.last = bif.m_last;
                    g.len  = int'(msg_len);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL group_unexpected: got data=%h nsym=%0d last=%0d len=%0d, required no group",
                                 g.data, g.nsym, g.last, g.len);
                    end else begin
                        e = exp_q[0];
                        if (g.data !== e.data || g.nsym != e.nsym || g.last != e.last ||
                            g.len != e.len || bif.s_ready !== 1'b0) begin
                            n_bad++;
                            $display("FAIL group: got data=%h nsym=%0d last=%0d len=%0d s_ready=%0b, required data=%h nsym=%0d last=%0d len=%0d s_ready=0",
                                     g.data, g.nsym, g.last, g.len, bif.s_ready, e.data, e.nsym, e.last, e.len);
                        end
                    end
                    if (bif.m_ready) begin
                        rx_q.push_back(g);
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                    end
                end
                if (bif.s_valid && bif.s_ready)
                    model_accept(int'(bif.s_data), bif.s_last);
            end
        end
    endtask

    // Downstream ready pattern: 0 random, 1 always ready, 2 stalled.
    task automatic drive_mready();
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       bif.m_ready = ($urandom_range(0, 3) != 0);
                1:       bif.m_ready = 1'b1;
                default: bif.m_ready = 1'b0;
            endcase
        end
    endtask

    task automatic send_char(input int c, input bit l, input int gap);
        int w;
        bif.s_valid = 1'b1;
        bif.s_data  = 7'(c);
        bif.s_last  = l;
        w = 0;
        forever begin
            @(negedge clk);
            if (bif.s_ready) break;
            w++;
            if (w > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles, required 1", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        bif.s_valid = 1'b0;
        bif.s_last  = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_char(int'(s[i]), (i == s.len() - 1), 0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bif.m_valid) break;
            w++;
            if (w > 500) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: got %0d groups outstanding, required 0", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input string name, input int idx, input logic [23:0] d,
                            input int ns, input bit l, input int ln);
        n_cmp++;
        if (idx >= rx_q.size()) begin
            n_bad++;
            $display("FAIL %s: got %0d groups, required group #%0d", name, rx_q.size(), idx);
        end else if (rx_q[idx].data !== d || rx_q[idx].nsym != ns ||
                     rx_q[idx].last != l || rx_q[idx].len != ln) begin
            n_bad++;
            $display("FAIL %s: got data=%h nsym=%0d last=%0d len=%0d, required data=%h nsym=%0d last=%0d len=%0d",
                     name, rx_q[idx].data, rx_q[idx].nsym, rx_q[idx].last, rx_q[idx].len, d, ns, l, ln);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (bif.s_ready !== 1'b0 || bif.m_valid !== 1'b0 || bif.m_data !== 24'd0 ||
            bif.m_nsym !== 3'd0 || bif.m_last !== 1'b0 || msg_len !== 8'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got s_ready=%b m_valid=%b m_data=%h m_nsym=%0d m_last=%b msg_len=%0d busy=%b, required all 0",
                     name, bif.s_ready, bif.m_valid, bif.m_data, bif.m_nsym, bif.m_last, msg_len, busy);
        end
    endtask

    initial begin
        int base;
        int len;
        rst_n       = 1'b0;
        bif.s_valid = 1'b0;
        bif.s_data  = 7'd0;
        bif.s_last  = 1'b0;
        bif.m_ready = 1'b1;
        fork
            monitor();
            drive_mready();
        join_none

        // Reset state, then idle state after release.
        #12;
        check_zero("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bif.s_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got s_ready=%b busy=%b, required s_ready=1 busy=0", bif.s_ready, busy);
        end

        // "Ab1z" -> {12,39,3,63}.
        base = rx_q.size();
        send_str("Ab1z");
        drain();
        check_rx("ab1z", base, 24'h3270FF, 4, 1'b1, 4);

        // "Hi!" -> {19,46,1,0}.
        base = rx_q.size();
        send_str("Hi!");
        drain();
        check_rx("hi_bang", base, 24'h4EE040, 3, 1'b1, 3);

        // Ten chars against a 20-cycle downstream stall.
        base = rx_q.size();
        mr_mode = 2;
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                mr_mode = 1;
            end
        join_none
        for (int i = 0; i < 10; i++)
            send_char(int'(alph[$urandom_range(0, 63)]), (i == 9), 0);
        drain();
        n_cmp++;
        if (rx_q.size() != base + 3 || rx_q[base].nsym != 4 ||
            rx_q[base + 1].nsym != 4 || rx_q[base + 2].nsym != 2) begin
            n_bad++;
            $display("FAIL stall_groups: got %0d groups, required 3 with nsym 4,4,2", rx_q.size() - base);
        end

        // 150 chars without s_last, closed by a 151st with s_last.
        base = rx_q.size();
        mr_mode = 0;
        for (int i = 0; i < 151; i++)
            send_char(int'(alph[$urandom_range(2, 63)]), (i == 150), 0);
        drain();
        n_cmp++;
        if (rx_q.size() != base + 39) begin
            n_bad++;
            $display("FAIL cap_group_count: got %0d groups, required 39", rx_q.size() - base);
        end
        if (rx_q.size() == base + 39) begin
            n_cmp++;
            if (rx_q[base + 36].nsym != 2 || rx_q[base + 36].last != 1'b1 ||
                rx_q[base + 36].len != 146 || rx_q[base + 35].last != 1'b0) begin
                n_bad++;
                $display("FAIL cap_group: got nsym=%0d last=%0d len=%0d, required nsym=2 last=1 len=146",
                         rx_q[base + 36].nsym, rx_q[base + 36].last, rx_q[base + 36].len);
            end
            n_cmp++;
            if (rx_q[base + 37].len != 4 || rx_q[base + 37].last != 1'b0 ||
                rx_q[base + 38].len != 5 || rx_q[base + 38].last != 1'b1 || rx_q[base + 38].nsym != 1) begin
                n_bad++;
                $display("FAIL after_cap: got len=%0d,%0d last=%0d,%0d, required len=4,5 last=0,1",
                         rx_q[base + 37].len, rx_q[base + 38].len, rx_q[base + 37].last, rx_q[base + 38].last);
            end
        end

        // Asynchronous reset after two chars of a group.
        mr_mode = 1;
        send_char(int'("Q"), 1'b0, 0);
        send_char(int'("r"), 1'b0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = rx_q.size();
        send_char(32, 1'b1, 0);
        drain();
        check_rx("space_after_reset", base, 24'h000000, 1, 1'b1, 1);

        // Randomized messages with random chars and downstream backpressure.
        mr_mode = 0;
        for (int m = 0; m < 40; m++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                send_char($urandom_range(0, 127), (i == len - 1), $urandom_range(0, 1));
        end
        drain();

`ifdef STRICT_CHECK_EN
        // Unmapped '#' packs as 0 and raises err until the next message starts.
        mr_mode = 1;
        base = rx_q.size();
        send_str("a#b");
        drain();
        check_rx("strict_a_hash_b", base, 24'h9809C0, 3, 1'b1, 3);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got err=%b, required 1", err);
        end
        send_char(int'("A"), 1'b1, 0);
        drain();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b, required 0", err);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
